// File: rtl/riscv_definitions.sv
// Shared RISC-V definitions.
//   funct3SType_e     : store access sizes (SB/SH/SW).
//   funct3ITypeLOAD_e : load access sizes and extension (LB/LH/LW/LBU/LHU).
//   dataBus_u         : 32-bit data bus viewed as word, halfwords or bytes.
//                       Element 0 of each view is the least significant part.
//   dmemState_e       : data memory responder FSM states.
package riscv_definitions;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } funct3SType_e;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } funct3ITypeLOAD_e;

  typedef union packed {
    logic [31:0]      word;
    logic [1:0][15:0] halves;
    logic [3:0][7:0]  bytes;
  } dataBus_u;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmemState_e;

endpackage

// File: rtl/dmem_ram.sv
// Word-organised storage for the data memory responder.
//   clk   : clock, all accesses on the rising edge.
//   we    : write strobe; only lanes with be[k]=1 are written.
//   be    : per-byte write enables, be[k] covers bits [8k+7:8k].
//   re    : read strobe; rdata is loaded from mem[idx] and then held.
//   idx   : word index.
//   wdata : lane-aligned write data.
//   rdata : registered read data, stable until the next read.
// Contents are never reset.
module dmem_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic             re,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
    if (re) rdata_q <= mem[idx];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: single-outstanding load/store slave with a fixed
// added latency of WAIT_CYCLES, little-endian byte lanes and sub-word
// sign/zero extension.
//   clk, rst       : clock; asynchronous active-high reset.
//   req_valid/ready: request handshake, ready only in IDLE.
//   req_write      : 1 = store, 0 = load.
//   req_funct3     : access size (store or load funct3 encoding).
//   req_addr       : byte address.
//   req_wdata      : right-aligned store data.
//   rsp_valid/ready: response handshake, response held until accepted.
//   rsp_rdata      : extended load data; 0 for stores and errors.
//   rsp_error      : misaligned, reserved funct3 or out-of-range access.
module data_mem_responder
  import riscv_definitions::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  dataBus_u    req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output dataBus_u    rsp_rdata,
  output logic        rsp_error
);

  localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  function automatic logic access_error(logic write, logic [2:0] f3, logic [31:0] addr);
    logic err;
    err = 1'b0;
    if (write) begin
      case (f3)
        SB:      err = 1'b0;
        SH:      err = addr[0];
        SW:      err = |addr[1:0];
        default: err = 1'b1;
      endcase
    end else begin
      case (f3)
        LB, LBU: err = 1'b0;
        LH, LHU: err = addr[0];
        LW:      err = |addr[1:0];
        default: err = 1'b1;
      endcase
    end
    if ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS)) err = 1'b1;
    return err;
  endfunction

  // Sub-word stores replicate the low bits across the word; the byte
  // enables pick which copy lands.
  function automatic logic [3:0] store_be(logic [2:0] f3, logic [1:0] ofs);
    logic [3:0] be;
    case (f3)
      SB:      be = 4'b0001 << ofs;
      SH:      be = ofs[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_data(logic [2:0] f3, dataBus_u wd);
    logic [31:0] d;
    case (f3)
      SB:      d = {4{wd.bytes[0]}};
      SH:      d = {2{wd.halves[0]}};
      default: d = wd.word;
    endcase
    return d;
  endfunction

  function automatic dataBus_u load_extend(logic [2:0] f3, logic [1:0] ofs, dataBus_u word);
    dataBus_u    res;
    logic [7:0]  b;
    logic [15:0] h;
    b = word.bytes[ofs];
    h = word.halves[ofs[1]];
    case (f3)
      LB:      res.word = {{24{b[7]}}, b};
      LBU:     res.word = {24'h0, b};
      LH:      res.word = {{16{h[15]}}, h};
      LHU:     res.word = {16'h0, h};
      LW:      res.word = word.word;
      default: res.word = '0;
    endcase
    return res;
  endfunction

  dmemState_e  state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        wr_q, wr_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  dataBus_u    wdata_q, wdata_d;

  logic        cur_write;
  logic [2:0]  cur_f3;
  logic [31:0] cur_addr;
  dataBus_u    cur_wdata;
  logic        enter_resp;
  logic        ram_we;
  logic        ram_re;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  dataBus_u    ram_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    wr_q    <= wr_d;
    f3_q    <= f3_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    wr_d       = wr_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    req_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          wr_d    = req_write;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d    = WAIT;
            wait_cnt_d = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // With no wait state the storage access happens on the accept edge itself,
  // so the live request inputs must feed the RAM instead of the latched copy.
  always_comb begin
    cur_write  = (state_q == IDLE) ? req_write  : wr_q;
    cur_f3     = (state_q == IDLE) ? req_funct3 : f3_q;
    cur_addr   = (state_q == IDLE) ? req_addr   : addr_q;
    cur_wdata  = (state_q == IDLE) ? req_wdata  : wdata_q;
    enter_resp = (state_d == RESP) && (state_q != RESP) && !rst;
    ram_we     = enter_resp && cur_write && !access_error(cur_write, cur_f3, cur_addr);
    ram_re     = enter_resp && !cur_write;
    ram_be     = store_be(cur_f3, cur_addr[1:0]);
    ram_wdata  = store_data(cur_f3, cur_wdata);
  end

  dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .be   (ram_be),
    .re   (ram_re),
    .idx  (cur_addr[IDX_W+1:2]),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  always_comb begin
    rsp_valid      = (state_q == RESP);
    rsp_error      = rsp_valid && access_error(wr_q, f3_q, addr_q);
    rsp_rdata.word = '0;
    if (rsp_valid && !wr_q && !rsp_error) begin
      rsp_rdata = load_extend(f3_q, addr_q[1:0], ram_rdata);
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (WAIT_CYCLES=1 and 3) driven
// through a common transaction task and checked against a byte-level model.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s       [2];
  logic        req_valid_s [2];
  logic        req_ready_s [2];
  logic        req_write_s [2];
  logic [2:0]  req_funct3_s[2];
  logic [31:0] req_addr_s  [2];
  logic [31:0] req_wdata_s [2];
  logic        rsp_valid_s [2];
  logic        rsp_ready_s [2];
  logic [31:0] rsp_rdata_s [2];
  logic        rsp_error_s [2];

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] mbytes[2][64];

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst(rst_s[0]),
    .req_valid(req_valid_s[0]), .req_ready(req_ready_s[0]), .req_write(req_write_s[0]),
    .req_funct3(req_funct3_s[0]), .req_addr(req_addr_s[0]), .req_wdata(req_wdata_s[0]),
    .rsp_valid(rsp_valid_s[0]), .rsp_ready(rsp_ready_s[0]),
    .rsp_rdata(rsp_rdata_s[0]), .rsp_error(rsp_error_s[0])
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) dut_w3 (
    .clk(clk), .rst(rst_s[1]),
    .req_valid(req_valid_s[1]), .req_ready(req_ready_s[1]), .req_write(req_write_s[1]),
    .req_funct3(req_funct3_s[1]), .req_addr(req_addr_s[1]), .req_wdata(req_wdata_s[1]),
    .rsp_valid(rsp_valid_s[1]), .rsp_ready(rsp_ready_s[1]),
    .rsp_rdata(rsp_rdata_s[1]), .rsp_error(rsp_error_s[1])
  );

  function automatic int wait_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Reference: byte-addressed little-endian memory, sizes from funct3.
  task automatic model_access(input int d, input bit wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic err);
    int size = 0;
    bit sgn = 1'b0;
    bit legal = 1'b1;
    logic [31:0] val;
    if (wr) begin
      case (f3)
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: legal = 1'b0;
      endcase
    end else begin
      case (f3)
        3'd0: begin size = 1; sgn = 1'b1; end
        3'd1: begin size = 2; sgn = 1'b1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: legal = 1'b0;
      endcase
    end
    err = !legal || ((addr % size) != 0) || ((addr / 4) >= 1024);
    rdata = 32'h0;
    if (!err) begin
      if (wr) begin
        for (int k = 0; k < size; k++) mbytes[d][int'(addr) + k] = wdata[8*k +: 8];
      end else begin
        val = 32'h0;
        for (int k = 0; k < size; k++) val = val | (32'(mbytes[d][int'(addr) + k]) << (8*k));
        if (sgn && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8*size));
        rdata = val;
      end
    end
  endtask

  // Runs one transaction; garbage is driven on req_* while the DUT is busy.
  // n_bad counts protocol slips: req_ready wrong, response unstable while
  // stalled, or rsp_valid not dropping / req_ready not returning after accept.
  task automatic do_txn(input int d, input bit wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int n_bad);
    bit seen;
    n_bad = 0;
    rdata = 32'hx;
    err   = 1'bx;
    @(negedge clk);
    if (req_ready_s[d] !== 1'b1) n_bad++;
    req_valid_s[d]  = 1'b1;
    req_write_s[d]  = wr;
    req_funct3_s[d] = f3;
    req_addr_s[d]   = addr;
    req_wdata_s[d]  = wdata;
    rsp_ready_s[d]  = 1'b0;
    @(posedge clk); #1;
    lat  = 1;
    seen = (rsp_valid_s[d] === 1'b1);
    if (req_ready_s[d] !== 1'b0) n_bad++;
    while (!seen && lat < 40) begin
      req_valid_s[d]  = 1'($urandom_range(0, 1));
      req_write_s[d]  = 1'($urandom_range(0, 1));
      req_funct3_s[d] = 3'($urandom_range(0, 7));
      req_addr_s[d]   = 32'($urandom_range(0, 63));
      req_wdata_s[d]  = $urandom;
      @(posedge clk); #1;
      lat++;
      seen = (rsp_valid_s[d] === 1'b1);
      if (req_ready_s[d] !== 1'b0) n_bad++;
    end
    req_valid_s[d] = 1'b0;
    if (!seen) begin
      lat = -1;
      return;
    end
    rdata = rsp_rdata_s[d];
    err   = rsp_error_s[d];
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (rsp_valid_s[d] !== 1'b1 || rsp_rdata_s[d] !== rdata ||
          rsp_error_s[d] !== err || req_ready_s[d] !== 1'b0) n_bad++;
    end
    rsp_ready_s[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready_s[d] = 1'b0;
    if (rsp_valid_s[d] !== 1'b0 || req_ready_s[d] !== 1'b1) n_bad++;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b1; req_valid_s[d] = 1'b0; req_write_s[d] = 1'b0;
      req_funct3_s[d] = 3'd0; req_addr_s[d] = 32'h0; req_wdata_s[d] = 32'h0;
      rsp_ready_s[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (req_ready_s[d] !== 1'b1 || rsp_valid_s[d] !== 1'b0 ||
          rsp_rdata_s[d] !== 32'h0 || rsp_error_s[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: ready=%b valid=%b rdata=%h err=%b, want 1 0 00000000 0",
                 d, req_ready_s[d], rsp_valid_s[d], rsp_rdata_s[d], rsp_error_s[d]);
      end
    end
    @(negedge clk);
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;
  endtask

  typedef struct packed {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } dir_t;

  task automatic test_directed();
    dir_t tab[14];
    logic [31:0] rd;
    logic er;
    int lat, bad;
    tab = '{
      '{1'b1, 3'd2, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0},
      '{1'b0, 3'd2, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0},
      '{1'b0, 3'd0, 32'h10,   32'h0,        32'hFFFFFFEF, 1'b0},
      '{1'b0, 3'd4, 32'h13,   32'h0,        32'h000000DE, 1'b0},
      '{1'b0, 3'd1, 32'h12,   32'h0,        32'hFFFFDEAD, 1'b0},
      '{1'b0, 3'd5, 32'h10,   32'h0,        32'h0000BEEF, 1'b0},
      '{1'b1, 3'd1, 32'h11,   32'hAAAA,     32'h0,        1'b1},
      '{1'b0, 3'd2, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0},
      '{1'b0, 3'd2, 32'h4000, 32'h0,        32'h0,        1'b1},
      '{1'b1, 3'd2, 32'hFFC,  32'h12345678, 32'h0,        1'b0},
      '{1'b0, 3'd2, 32'hFFC,  32'h0,        32'h12345678, 1'b0},
      '{1'b0, 3'd2, 32'h1000, 32'h0,        32'h0,        1'b1},
      '{1'b1, 3'd3, 32'h10,   32'h11111111, 32'h0,        1'b1},
      '{1'b0, 3'd6, 32'h10,   32'h0,        32'h0,        1'b1}
    };
    foreach (tab[i]) begin
      do_txn(0, tab[i].wr, tab[i].f3, tab[i].addr, tab[i].wdata, 0, rd, er, lat, bad);
      n_cmp++;
      if (lat !== 2) begin
        n_fail++;
        $display("FAIL dir[%0d] latency: got %0d want 2", i, lat);
      end
      n_cmp++;
      if (rd !== tab[i].exp_rd || er !== tab[i].exp_err) begin
        n_fail++;
        $display("FAIL dir[%0d] data: got %h/%b want %h/%b", i, rd, er, tab[i].exp_rd, tab[i].exp_err);
      end
      n_cmp++;
      if (bad !== 0) begin
        n_fail++;
        $display("FAIL dir[%0d] protocol: %0d slips want 0", i, bad);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd;
    logic er;
    int lat, bad;
    do_txn(0, 1'b0, 3'd2, 32'h10, 32'h0, 5, rd, er, lat, bad);
    n_cmp++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 2) begin
      n_fail++;
      $display("FAIL stall data: got %h/%b lat %0d want deadbeef/0 lat 2", rd, er, lat);
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL stall protocol: %0d slips want 0", bad);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd, exp_rd;
    logic er, exp_er;
    int lat, bad;
    do_txn(1, 1'b1, 3'd2, 32'h20, 32'h0, 0, rd, er, lat, bad);
    model_access(1, 1'b1, 3'd2, 32'h20, 32'h0, exp_rd, exp_er);
    n_cmp++;
    if (er !== 1'b0 || lat !== 4 || bad !== 0) begin
      n_fail++;
      $display("FAIL rstwait setup: err %b lat %0d slips %0d want 0 4 0", er, lat, bad);
    end
    @(negedge clk);
    req_valid_s[1] = 1'b1; req_write_s[1] = 1'b1; req_funct3_s[1] = 3'd0;
    req_addr_s[1] = 32'h20; req_wdata_s[1] = 32'h55;
    @(posedge clk); #1;
    req_valid_s[1] = 1'b0;
    n_cmp++;
    if (req_ready_s[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL rstwait accept: req_ready %b want 0", req_ready_s[1]);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_s[1] = 1'b1;
    #1;
    n_cmp++;
    if (rsp_valid_s[1] !== 1'b0 || req_ready_s[1] !== 1'b1 ||
        rsp_rdata_s[1] !== 32'h0 || rsp_error_s[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL rstwait async: valid %b ready %b rdata %h err %b want 0 1 0 0",
               rsp_valid_s[1], req_ready_s[1], rsp_rdata_s[1], rsp_error_s[1]);
    end
    @(negedge clk);
    rst_s[1] = 1'b0;
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (rsp_valid_s[1] !== 1'b0 || req_ready_s[1] !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL rstwait idle: %0d cycles not idle want 0", bad);
    end
    do_txn(1, 1'b0, 3'd2, 32'h20, 32'h0, 0, rd, er, lat, bad);
    model_access(1, 1'b0, 3'd2, 32'h20, 32'h0, exp_rd, exp_er);
    n_cmp++;
    if (rd !== exp_rd || er !== exp_er || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL rstwait readback: got %h/%b want %h/%b", rd, er, exp_rd, exp_er);
    end
  endtask

  task automatic test_random(input int d, input int n_ops);
    logic [31:0] rd, exp_rd, addr, wdata;
    logic er, exp_er;
    logic [2:0] f3;
    bit wr;
    int lat, bad, hold;
    for (int w = 0; w < 16; w++) begin
      wdata = $urandom;
      do_txn(d, 1'b1, 3'd2, 32'(w * 4), wdata, 0, rd, er, lat, bad);
      model_access(d, 1'b1, 3'd2, 32'(w * 4), wdata, exp_rd, exp_er);
      n_cmp++;
      if (er !== 1'b0 || lat !== wait_of(d) + 1 || bad !== 0) begin
        n_fail++;
        $display("FAIL rand%0d init[%0d]: err %b lat %0d slips %0d", d, w, er, lat, bad);
      end
    end
    for (int i = 0; i < n_ops; i++) begin
      wr    = 1'($urandom_range(0, 1));
      f3    = 3'($urandom_range(0, 7));
      wdata = $urandom;
      hold  = $urandom_range(0, 2);
      if ($urandom_range(0, 7) == 0) addr = 32'h1000 | $urandom;
      else addr = 32'($urandom_range(0, 63));
      do_txn(d, wr, f3, addr, wdata, hold, rd, er, lat, bad);
      model_access(d, wr, f3, addr, wdata, exp_rd, exp_er);
      n_cmp++;
      if (rd !== exp_rd || er !== exp_er) begin
        n_fail++;
        $display("FAIL rand%0d op%0d wr=%b f3=%0d addr=%h: got %h/%b want %h/%b",
                 d, i, wr, f3, addr, rd, er, exp_rd, exp_er);
      end
      n_cmp++;
      if (lat !== wait_of(d) + 1 || bad !== 0) begin
        n_fail++;
        $display("FAIL rand%0d op%0d timing: lat %0d slips %0d want %0d 0",
                 d, i, lat, bad, wait_of(d) + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_in_wait();
    test_random(0, 80);
    test_random(1, 80);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
